// File: rtl/gpr_pkg.sv
// Shared constants and FSM encoding for the GPR write-port arbiter.
package gpr_pkg;
  localparam int GPR_AW   = 5;
  localparam int GPR_DW   = 32;
  localparam int REG_ZERO = 0;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } arb_state_e;
endpackage

// File: rtl/gpr_scoreboard.sv
// Pending-register mask for outstanding long-latency results; set beats clear.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int AW = GPR_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_adr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_adr,
  input  logic [AW-1:0] rd_adr1,
  input  logic [AW-1:0] rd_adr2,
  input  logic [AW-1:0] chk_adr,
  output logic          rd_stall,
  output logic          waw_stall,
  output logic          chk_hit
);
  localparam int NR = 1 << AW;

  logic [NR-1:0] pending;
  logic [NR-1:0] set_mask;
  logic [NR-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en && set_adr != AW'(REG_ZERO)) set_mask[set_adr] = 1'b1;
    if (clr_en) clr_mask[clr_adr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) pending <= '0;
    else      pending <= (pending & ~clr_mask) | set_mask;
  end

  assign rd_stall  = (rd_adr1 != AW'(REG_ZERO) && pending[rd_adr1]) ||
                     (rd_adr2 != AW'(REG_ZERO) && pending[rd_adr2]);
  assign waw_stall = set_en && pending[set_adr];
  assign chk_hit   = pending[chk_adr];
endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: priority pipeline writeback, buffered long-latency
// results, pending scoreboard and a starvation guard that forces B through.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int AW           = GPR_AW,
  parameter int DW           = GPR_DW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_wr,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_data,
  output logic          a_hold,
  input  logic          b_issue,
  input  logic [AW-1:0] b_issue_adr,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_data,
  input  logic [AW-1:0] rd_adr1,
  input  logic [AW-1:0] rd_adr2,
  output logic          rd_stall,
  output logic          waw_stall,
  output logic          gpr_wr,
  output logic [AW-1:0] gpr_wr_adr,
  output logic [DW-1:0] gpr_wr_data,
  output logic          err
);
  logic             buf_full;
  logic [AW-1:0]    buf_adr;
  logic [DW-1:0]    buf_data;
  arb_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             a_hold_nx;
  logic             gnt_a, gnt_b;
  logic             a_hit;

  assign gnt_b   = buf_full && (state == FORCE || !a_wr);
  assign gnt_a   = a_wr && !gnt_b;
  assign b_ready = !buf_full;

  always_comb begin
    gpr_wr      = gnt_a | gnt_b;
    gpr_wr_adr  = '0;
    gpr_wr_data = '0;
    if (gnt_b) begin
      gpr_wr_adr  = buf_adr;
      gpr_wr_data = buf_data;
    end else if (gnt_a) begin
      gpr_wr_adr  = a_adr;
      gpr_wr_data = a_data;
    end
  end

  // Holding buffer: fill only when empty, so it never refills on its drain cycle.
  always_ff @(posedge clk) begin
    if (!rst)                 buf_full <= 1'b0;
    else if (gnt_b)           buf_full <= 1'b0;
    else if (b_valid && b_ready) buf_full <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (b_valid && b_ready) begin
      buf_adr  <= b_adr;
      buf_data <= b_data;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    a_hold_nx = a_hold;
    case (state)
      IDLE: begin
        if (buf_full && a_wr) begin
          cnt_nx = CNT_W'(1);
          if (STARVE_LIMIT == 1) begin
            state_nx  = FORCE;
            a_hold_nx = 1'b1;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        if (gnt_b) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (a_wr) begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt_nx == CNT_W'(STARVE_LIMIT)) begin
            state_nx  = FORCE;
            a_hold_nx = 1'b1;
          end
        end
      end
      FORCE: begin
        state_nx  = IDLE;
        cnt_nx    = '0;
        a_hold_nx = 1'b0;
      end
      default: begin
        state_nx  = IDLE;
        cnt_nx    = '0;
        a_hold_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_hold <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      a_hold <= a_hold_nx;
      // Sticky: WAW issue, A writing a pending register, or A ignoring a_hold.
      err    <= err | waw_stall | (a_wr && a_hit) | (state == FORCE && a_wr);
    end
  end

  gpr_scoreboard #(.AW(AW)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (b_issue),
    .set_adr   (b_issue_adr),
    .clr_en    (gnt_b),
    .clr_adr   (buf_adr),
    .rd_adr1   (rd_adr1),
    .rd_adr2   (rd_adr2),
    .chk_adr   (a_adr),
    .rd_stall  (rd_stall),
    .waw_stall (waw_stall),
    .chk_hit   (a_hit)
  );
endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
Shares the GPR file's single write port between two writers.
- Requester A: the in-order pipeline writeback. It has priority and no backpressure.
- Requester B: a long-latency unit (mul/div or load return). It uses a valid/ready handshake into a one-entry holding buffer.
The block keeps a 32-bit pending-register scoreboard so decode can stall on outstanding B results. It also runs a starvation FSM that briefly holds off A so B always drains. It sits between the writeback stage and the GPR write port (GPRWr / DATA_WRITE_ADR / DATA_WRITE).

Parameters:
- AW, 5, GPR address width (32 registers).
- DW, 32, data width.
- STARVE_LIMIT, 4, cycles a full buffer may lose to A before the FSM forces a B grant (legal range 1..15).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge).
- a_wr  in  1  pipeline writeback request.
- a_adr  in  AW  pipeline destination register.
- a_data  in  DW  pipeline write data.
- a_hold  out  1  registered; pipeline must not assert a_wr while high.
- b_issue  in  1  B op issued; reserves its destination.
- b_issue_adr  in  AW  destination of the issued B op.
- b_valid  in  1  B result valid.
- b_ready  out  1  buffer empty; B result accepted when b_valid&&b_ready.
- b_adr  in  AW  B result destination.
- b_data  in  DW  B result data.
- rd_adr1  in  AW  decode read address 1.
- rd_adr2  in  AW  decode read address 2.
- rd_stall  out  1  a read address is pending in the scoreboard.
- waw_stall  out  1  b_issue_adr already pending.
- gpr_wr  out  1  to GPR GPRWr.
- gpr_wr_adr  out  AW  to GPR DATA_WRITE_ADR.
- gpr_wr_data  out  DW  to GPR DATA_WRITE.
- err  out  1  sticky protocol-error flag.

Behaviour:
Reset (rst==0 at posedge):
- pending=0, buffer empty, state=IDLE, starve counter=0, a_hold=0, err=0.
- Consequently b_ready=1, gpr_wr=0.
- Reset mid-operation discards the buffer contents and all pending bits.

Write mux (combinational, same cycle):
- gnt_b = buf_full && (state==FORCE || !a_wr); gnt_a = a_wr && !gnt_b.
- gpr_wr = gnt_a | gnt_b. Address and data come from the granted source, and are 0 when idle.
- A reaches the GPR with zero latency. A B result captured at edge N commits no earlier than cycle N+1.

Buffer:
- Captures b_adr/b_data on b_valid&&b_ready.
- Clears on gnt_b.
- b_ready = !buf_full. It is not combinationally refilled in the cycle it drains, so the buffer holds one entry maximum.

Scoreboard:
- b_issue with b_issue_adr!=0 sets pending[b_issue_adr].
- gnt_b clears pending[buffer adr].
- If set and clear hit the same register in the same cycle, set wins.
- pending[0] is never set.
- rd_stall = (rd_adr1!=0 && pending[rd_adr1]) || (rd_adr2!=0 && pending[rd_adr2]).
- waw_stall = b_issue && pending[b_issue_adr]. Issue logic must withhold b_issue while this is high; if b_issue occurs anyway, err is set.

Starvation FSM (states IDLE, WAIT, FORCE):
- IDLE -> WAIT when buf_full && a_wr; counter=1.
- WAIT, A wins again: counter++. When counter==STARVE_LIMIT, -> FORCE and a_hold=1 on the same edge.
- WAIT, B granted: -> IDLE, counter=0.
- FORCE: B granted unconditionally. If a_wr is asserted anyway, the A write is dropped and err=1. Next edge -> IDLE, a_hold=0, counter=0.
- With STARVE_LIMIT=1, the first lost cycle goes directly to FORCE.

Boundary cases:
- A write to a pending register sets err; the write still proceeds.
- B result to address 0 drains normally. gpr_wr is asserted and the GPR ignores it.
- B accept and A write in the same cycle: A commits and the buffer fills.

Decomposition:
- Shared package gpr_pkg holds: AW/DW constants, the REG_ZERO constant, and the FSM state encoding (2-bit enum: IDLE=0, WAIT=1, FORCE=2).
- One natural sub-module, gpr_scoreboard: pending mask, set/clear priority, and the rd_stall/waw_stall compare.
- Mux, buffer and FSM stay in the top level.

Test Plan:
1. Reset then idle -> gpr_wr=0, b_ready=1, a_hold=0, rd_stall=0, err=0.
2. b_issue adr=5; rd_adr1=5 next cycle -> rd_stall=1. Then b_valid adr=5 data=0x1234 with a_wr=0 -> gpr_wr=1 adr=5 data=0x1234 the following cycle; rd_stall falls one edge later.
3. Buffer full (adr=7), a_wr held high with STARVE_LIMIT=4 -> A wins 4 cycles, a_hold=1 on the 5th cycle, B (adr=7) written in FORCE, a_hold=0 after.
4. b_issue adr=9 in the same cycle the buffered adr=9 result commits -> pending[9] remains 1.
5. a_wr=1 during FORCE -> A dropped, B written, err=1 and stays 1 until reset.
6. Reset asserted while buffer full and pending[3]=1 -> buffer empty, pending=0, no gpr_wr next cycle.
